pipe_stage_elastic: RTL and testbench

Parametrised, flushable pipeline stage register with a valid/ready handshake. It is the next-generation replacement for the fixed-field, enable-only stage registers between IF/ID/EX/MEM/WB. The payload is split into a data field and a control field. The control field reads as all-zero (a NOP) whenever the stage holds no valid entry. An optional 2-entry skid buffer lets the stage run at full throughput with a registered `in_ready`.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/stage_reg_n.sv | 26 ++
 rtl/pipe_stage_elastic.sv | 200 ++++++++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage.
package pipe_pkg;

   // Occupancy of the two-entry skid variant.
   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_TWO
   } pipe_state_t;

   localparam int unsigned BUBBLE_CNT_W = 32;

endpackage

// File: rtl/stage_reg_n.sv
// Width-parametrised register with load enable and synchronous clear.
module stage_reg_n #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         clear,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;

   // Clear (or reset) wins over a load in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         q_q <= '0;
      end else if (enable) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Flushable valid/ready pipeline stage with optional 2-entry skid buffer.
// Control payload reads as zero (NOP) whenever no entry is held.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CTRL_W = 16,
   parameter bit          SKID   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [CTRL_W-1:0]       in_ctrl,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic [CTRL_W-1:0]       out_ctrl,
   output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

   logic              in_fire;
   logic              out_fire;
   logic              main_load;
   logic              main_sel_skid;
   logic              main_ctrl_clr;
   logic [DATA_W-1:0] main_data_d;
   logic [CTRL_W-1:0] main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q;
   logic [CTRL_W-1:0] skid_ctrl_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Head refills from the skid entry when draining TWO, otherwise from upstream.
   assign main_data_d = main_sel_skid ? skid_data_q : in_data;
   assign main_ctrl_d = main_sel_skid ? skid_ctrl_q : in_ctrl;

   // Data holds its value when vacated; only reset zeroes it.
   stage_reg_n #(.W(DATA_W)) u_main_data (
      .clk    (clk),
      .reset  (reset),
      .enable (main_load),
      .clear  (1'b0),
      .d_i    (main_data_d),
      .q_o    (out_data)
   );

   // Control is cleared on vacate, so out_ctrl needs no output gating.
   stage_reg_n #(.W(CTRL_W)) u_main_ctrl (
      .clk    (clk),
      .reset  (reset),
      .enable (main_load),
      .clear  (main_ctrl_clr),
      .d_i    (main_ctrl_d),
      .q_o    (out_ctrl)
   );

   if (SKID) begin : g_skid
      pipe_state_t state_q, state_d;
      logic        ready_q;
      logic        skid_load;
      logic        skid_ctrl_clr;

      // Next-state and register-load decode; flush overrides any transfer.
      always_comb begin
         state_d       = state_q;
         main_load     = 1'b0;
         main_sel_skid = 1'b0;
         main_ctrl_clr = 1'b0;
         skid_load     = 1'b0;
         skid_ctrl_clr = 1'b0;
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_load = 1'b1;
                  state_d   = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  skid_load = 1'b1;
                  state_d   = ST_TWO;
               end else if (out_fire) begin
                  main_ctrl_clr = 1'b1;
                  state_d       = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  main_load     = 1'b1;
                  main_sel_skid = 1'b1;
                  skid_ctrl_clr = 1'b1;
                  state_d       = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
         if (flush) begin
            state_d       = ST_EMPTY;
            main_load     = 1'b0;
            skid_load     = 1'b0;
            main_ctrl_clr = 1'b1;
            skid_ctrl_clr = 1'b1;
         end
      end

      // State plus a dedicated ready flop so in_ready has no path from out_ready.
      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
         end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_TWO);
         end
      end

      assign in_ready  = ready_q;
      assign out_valid = (state_q != ST_EMPTY);

      stage_reg_n #(.W(DATA_W)) u_skid_data (
         .clk    (clk),
         .reset  (reset),
         .enable (skid_load),
         .clear  (1'b0),
         .d_i    (in_data),
         .q_o    (skid_data_q)
      );

      stage_reg_n #(.W(CTRL_W)) u_skid_ctrl (
         .clk    (clk),
         .reset  (reset),
         .enable (skid_load),
         .clear  (skid_ctrl_clr),
         .d_i    (in_ctrl),
         .q_o    (skid_ctrl_q)
      );
   end else begin : g_single
      logic valid_q, valid_d;

      // Single-register occupancy; flush overrides any transfer.
      always_comb begin
         valid_d       = valid_q;
         main_load     = 1'b0;
         main_ctrl_clr = 1'b0;
         if (flush) begin
            valid_d       = 1'b0;
            main_ctrl_clr = 1'b1;
         end else if (in_fire) begin
            valid_d   = 1'b1;
            main_load = 1'b1;
         end else if (out_fire) begin
            valid_d       = 1'b0;
            main_ctrl_clr = 1'b1;
         end
      end

      // Valid flag for the single entry.
      always_ff @(posedge clk) begin
         if (reset) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= valid_d;
         end
      end

      assign in_ready      = out_ready | ~valid_q;
      assign out_valid     = valid_q;
      assign main_sel_skid = 1'b0;
      assign skid_data_q   = '0;
      assign skid_ctrl_q   = '0;
   end

   logic [BUBBLE_CNT_W-1:0] bubble_q, bubble_d;

   // Count empty-output cycles, saturating at all-ones.
   always_comb begin
      bubble_d = bubble_q;
      if (!out_valid && (bubble_q != '1)) begin
         bubble_d = bubble_q + BUBBLE_CNT_W'(1);
      end
   end

   // Bubble counter survives flush; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_q <= '0;
      end else begin
         bubble_q <= bubble_d;
      end
   end

   assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic in both skid and single-register modes.
module tb_pipe_stage_elastic;

   logic        clk;
   logic        rst;

   logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [63:0] s_in_data, s_out_data;
   logic [15:0] s_in_ctrl, s_out_ctrl;
   logic [31:0] s_bubble;

   logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
   logic [63:0] n_in_data, n_out_data;
   logic [15:0] n_in_ctrl, n_out_ctrl;
   logic [31:0] n_bubble;

   int n_assert = 0;
   int n_fail   = 0;

   pipe_stage_elastic #(.DATA_W(64), .CTRL_W(16), .SKID(1'b1)) u_skid (
      .clk        (clk),
      .reset      (rst),
      .flush      (s_flush),
      .in_valid   (s_in_valid),
      .in_ready   (s_in_ready),
      .in_data    (s_in_data),
      .in_ctrl    (s_in_ctrl),
      .out_valid  (s_out_valid),
      .out_ready  (s_out_ready),
      .out_data   (s_out_data),
      .out_ctrl   (s_out_ctrl),
      .bubble_cnt (s_bubble)
   );

   pipe_stage_elastic #(.DATA_W(64), .CTRL_W(16), .SKID(1'b0)) u_single (
      .clk        (clk),
      .reset      (rst),
      .flush      (n_flush),
      .in_valid   (n_in_valid),
      .in_ready   (n_in_ready),
      .in_data    (n_in_data),
      .in_ctrl    (n_in_ctrl),
      .out_valid  (n_out_valid),
      .out_ready  (n_out_ready),
      .out_data   (n_out_data),
      .out_ctrl   (n_out_ctrl),
      .bubble_cnt (n_bubble)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int   sent;
      int   recv;
      logic ev;
      logic exp_rdy;

      rst         = 1'b1;
      s_flush     = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
      s_in_data   = '0;   s_in_ctrl  = '0;
      n_flush     = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b0;
      n_in_data   = '0;   n_in_ctrl  = '0;

      // Reset values
      @(negedge clk);
      chk("rst_s_out_valid", s_out_valid, 0);
      chk("rst_s_out_ctrl",  s_out_ctrl,  0);
      chk("rst_s_out_data",  s_out_data,  0);
      chk("rst_s_in_ready",  s_in_ready,  1);
      chk("rst_s_bubble",    s_bubble,    0);
      chk("rst_n_out_valid", n_out_valid, 0);
      chk("rst_n_in_ready",  n_in_ready,  1);
      chk("rst_n_bubble",    n_bubble,    0);

      // Streaming at full rate, both modes
      rst = 1'b0;
      s_out_ready = 1'b1;
      n_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_in_valid = 1'b1; s_in_data = 64'h10 + 64'(i); s_in_ctrl = 16'h1 + 16'(i);
         n_in_valid = 1'b1; n_in_data = 64'h10 + 64'(i); n_in_ctrl = 16'h1 + 16'(i);
         @(negedge clk);
         chk("str_s_valid", s_out_valid, 1);
         chk("str_s_data",  s_out_data,  64'h10 + 64'(i));
         chk("str_s_ctrl",  s_out_ctrl,  16'h1 + 16'(i));
         chk("str_s_ready", s_in_ready,  1);
         chk("str_n_data",  n_out_data,  64'h10 + 64'(i));
         chk("str_n_ctrl",  n_out_ctrl,  16'h1 + 16'(i));
         chk("str_n_ready", n_in_ready,  1);
      end
      chk("str_s_bubble", s_bubble, 1);
      chk("str_n_bubble", n_bubble, 1);
      s_in_valid = 1'b0;
      n_in_valid = 1'b0;
      @(negedge clk);
      chk("drain_s_valid",  s_out_valid, 0);
      chk("drain_s_ctrl",   s_out_ctrl,  0);
      chk("drain_s_bubble", s_bubble,    1);
      chk("drain_n_valid",  n_out_valid, 0);

      // Skid fill to TWO, then drain in order
      s_out_ready = 1'b0;
      s_in_valid = 1'b1; s_in_data = 64'hAA; s_in_ctrl = 16'h0A;
      @(negedge clk);
      chk("fill_a_ready", s_in_ready, 1);
      chk("fill_a_valid", s_out_valid, 1);
      chk("fill_a_data",  s_out_data, 64'hAA);
      chk("fill_a_ctrl",  s_out_ctrl, 16'h0A);
      s_in_data = 64'hBB; s_in_ctrl = 16'h0B;
      @(negedge clk);
      chk("fill_b_ready", s_in_ready, 0);
      chk("fill_b_head",  s_out_data, 64'hAA);
      s_in_valid = 1'b0; s_out_ready = 1'b1;
      @(negedge clk);
      chk("pop1_valid", s_out_valid, 1);
      chk("pop1_data",  s_out_data, 64'hBB);
      chk("pop1_ctrl",  s_out_ctrl, 16'h0B);
      chk("pop1_ready", s_in_ready, 1);
      @(negedge clk);
      chk("pop2_valid",  s_out_valid, 0);
      chk("pop2_ctrl",   s_out_ctrl,  0);
      chk("pop2_bubble", s_bubble,    2);

      // Flush in TWO with a pending input; single-mode flush with in and out fire
      s_out_ready = 1'b0;
      s_in_valid = 1'b1; s_in_data = 64'hDD; s_in_ctrl = 16'h0D;
      n_out_ready = 1'b0;
      n_in_valid = 1'b1; n_in_data = 64'h66; n_in_ctrl = 16'h06;
      @(negedge clk);
      s_in_data = 64'hEE; s_in_ctrl = 16'h0E;
      n_in_valid = 1'b0;
      @(negedge clk);
      chk("pre_fl_s_ready", s_in_ready, 0);
      chk("pre_fl_s_data",  s_out_data, 64'hDD);
      chk("pre_fl_n_ctrl",  n_out_ctrl, 16'h06);
      s_flush = 1'b1; s_in_valid = 1'b1; s_in_data = 64'hCC; s_in_ctrl = 16'h0C;
      n_flush = 1'b1; n_out_ready = 1'b1;
      n_in_valid = 1'b1; n_in_data = 64'h77; n_in_ctrl = 16'h07;
      @(negedge clk);
      chk("fl_s_valid", s_out_valid, 0);
      chk("fl_s_ctrl",  s_out_ctrl,  0);
      chk("fl_s_ready", s_in_ready,  1);
      chk("fl_n_valid", n_out_valid, 0);
      chk("fl_n_ctrl",  n_out_ctrl,  0);
      s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
      n_flush = 1'b0; n_in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("post_fl_s_valid", s_out_valid, 0);
         chk("post_fl_s_ctrl",  s_out_ctrl,  0);
         chk("post_fl_n_valid", n_out_valid, 0);
      end

      // Single mode, alternating out_ready, 16 entries
      sent = 0;
      recv = 0;
      ev   = 1'b0;
      for (int cyc = 0; cyc < 80 && recv < 16; cyc++) begin
         n_out_ready = (cyc % 2 == 0);
         n_in_valid  = (sent < 16);
         n_in_data   = 64'h40 + 64'(sent);
         n_in_ctrl   = 16'h1 + 16'(sent);
         #1;
         exp_rdy = n_out_ready | ~ev;
         chk("alt_ready", n_in_ready, exp_rdy);
         chk("alt_valid", n_out_valid, ev);
         if (ev && n_out_ready) begin
            chk("alt_order", n_out_data, 64'h40 + 64'(recv));
            recv++;
         end
         if (n_in_valid && exp_rdy) begin
            ev = 1'b1;
            sent++;
         end else if (ev && n_out_ready) begin
            ev = 1'b0;
         end
         @(negedge clk);
      end
      chk("alt_recv_count", recv, 16);
      n_in_valid = 1'b0;

      // Reset while in TWO with out_ready high
      s_out_ready = 1'b0;
      s_in_valid = 1'b1; s_in_data = 64'hF1; s_in_ctrl = 16'h11;
      @(negedge clk);
      s_in_data = 64'hF2; s_in_ctrl = 16'h12;
      @(negedge clk);
      chk("pre_rst_ready", s_in_ready, 0);
      rst = 1'b1; s_out_ready = 1'b1; s_in_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid",  s_out_valid, 0);
      chk("mid_rst_ctrl",   s_out_ctrl,  0);
      chk("mid_rst_data",   s_out_data,  0);
      chk("mid_rst_ready",  s_in_ready,  1);
      chk("mid_rst_bubble", s_bubble,    0);
      rst = 1'b0;

      // Bubble counter saturation
      u_skid.bubble_q = 32'hFFFF_FFFD;
      @(negedge clk);
      chk("sat_step1", s_bubble, 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) @(negedge clk);
      chk("sat_hold", s_bubble, 32'hFFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
